// File: rtl/cache_line_store.sv
// cache_line_store
// ----------------
// Direct-mapped cache storage with multi-word lines. Each line carries a tag,
// a valid bit and a dirty bit. Lookups complete one cycle after acceptance and
// always report the indexed line's prior state (the "victim") so the cache
// controller can decide whether a write-back is needed before a refill.
// Lines are refilled by a burst of LINE_WORDS beats through the fill port.
//
// Address layout: addr = {tag, index, offset}.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   lookup handshake (ready only when idle and no
//                         fill_start / flush_all this cycle)
//   req_we, req_addr,     lookup kind, word address, write data
//   req_wdata
//   rsp_valid             one-cycle pulse the cycle after a lookup is accepted
//   rsp_hit, rsp_rdata    hit flag and read word (rdata valid on read hit only)
//   rsp_victim_*          valid/dirty/tag of the indexed line before the access
//   fill_start, fill_addr begin a refill of the line holding fill_addr
//   fill_valid, fill_data refill beats, written in ascending word order
//   fill_done             one-cycle pulse after the last beat is written
//   busy                  high while a refill is in progress
//   flush_all             invalidate every line; aborts any refill

module cache_line_store #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_victim_valid,
    output logic                  rsp_victim_dirty,
    output logic [ADDR_WIDTH-$clog2(NUM_LINES)-$clog2(LINE_WORDS)-1:0] rsp_victim_tag,

    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_done,
    output logic                  busy,

    input  logic                  flush_all
);

    localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W     = $clog2(NUM_LINES);
    localparam int unsigned TAG_W     = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int unsigned MEM_DEPTH = NUM_LINES * LINE_WORDS;

    localparam logic [OFF_W-1:0] LastBeat = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]       fill_tag_q, fill_tag_d;

    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [NUM_LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    logic [TAG_W-1:0]       tag_d [NUM_LINES];

    // Word storage, flattened as {index, offset}; never reset.
    logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];
    logic                   mem_we;
    logic [IDX_W+OFF_W-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   vic_valid_q, vic_valid_d;
    logic                   vic_dirty_q, vic_dirty_d;
    logic [TAG_W-1:0]       vic_tag_q, vic_tag_d;
    logic                   fill_done_q, fill_done_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic             unused_fill_off;

    assign req_tag  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_off  = req_addr[OFF_W-1:0];
    assign fill_tag = fill_addr[ADDR_WIDTH-1 -: TAG_W];
    assign fill_idx = fill_addr[OFF_W +: IDX_W];

    // Refills always start at word 0, so the offset of fill_addr is ignored.
    assign unused_fill_off = ^fill_addr[OFF_W-1:0];

    // ------------------------------------------------------------------
    // Handshake and lookup
    // ------------------------------------------------------------------
    logic accept;
    logic lookup_hit;

    // flush_all beats fill_start beats a request in the same cycle.
    assign req_ready  = (state_q == StIdle) && !fill_start && !flush_all;
    assign accept     = req_valid && req_ready;
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_idx_d  = fill_idx_q;
        fill_tag_d  = fill_tag_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;

        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;

        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_rdata_d = rsp_rdata_q;
        vic_valid_d = vic_valid_q;
        vic_dirty_d = vic_dirty_q;
        vic_tag_d   = vic_tag_q;
        fill_done_d = 1'b0;

        if (flush_all) begin
            // Aborts any refill; beats still in flight are dropped upstream.
            valid_d = '0;
            dirty_d = '0;
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fill_start) begin
                        fill_idx_d        = fill_idx;
                        fill_tag_d        = fill_tag;
                        valid_d[fill_idx] = 1'b0;
                        cnt_d             = '0;
                        state_d           = StFill;
                    end else if (accept) begin
                        // Response reflects the line as it was before this access.
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = lookup_hit;
                        rsp_rdata_d = mem_q[{req_idx, req_off}];
                        vic_valid_d = valid_q[req_idx];
                        vic_dirty_d = dirty_q[req_idx];
                        vic_tag_d   = tag_q[req_idx];
                        // Write misses do not allocate.
                        if (req_we && lookup_hit) begin
                            mem_we           = 1'b1;
                            mem_waddr        = {req_idx, req_off};
                            mem_wdata        = req_wdata;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end
                end

                StFill: begin
                    if (fill_valid) begin
                        mem_we    = 1'b1;
                        mem_waddr = {fill_idx_q, cnt_q};
                        mem_wdata = fill_data;
                        cnt_d     = cnt_q + 1'b1;  // wraps to 0 after the last beat
                        if (cnt_q == LastBeat) begin
                            valid_d[fill_idx_q] = 1'b1;
                            dirty_d[fill_idx_q] = 1'b0;
                            tag_d[fill_idx_q]   = fill_tag_q;
                            state_d             = StIdle;
                            fill_done_d         = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            fill_idx_q  <= '0;
            fill_tag_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_rdata_q <= '0;
            vic_valid_q <= 1'b0;
            vic_dirty_q <= 1'b0;
            vic_tag_q   <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_idx_q  <= fill_idx_d;
            fill_tag_q  <= fill_tag_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_rdata_q <= rsp_rdata_d;
            vic_valid_q <= vic_valid_d;
            vic_dirty_q <= vic_dirty_d;
            vic_tag_q   <= vic_tag_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_victim_valid = vic_valid_q;
    assign rsp_victim_dirty = vic_dirty_q;
    assign rsp_victim_tag   = vic_tag_q;
    assign fill_done        = fill_done_q;
    assign busy             = (state_q == StFill);

endmodule

// File: tb/tb_cache_line_store.sv
// Self-checking bench for cache_line_store. A line-level reference model is
// stepped once per clock edge from the stimulus; expected lookup responses are
// queued and a negedge monitor pops and compares them.

module tb_cache_line_store;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned NL    = 8;
    localparam int unsigned OFF_W = $clog2(LW);
    localparam int unsigned IDX_W = $clog2(NL);
    localparam int unsigned TAG_W = AW - IDX_W - OFF_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_victim_valid;
    logic              rsp_victim_dirty;
    logic [TAG_W-1:0]  rsp_victim_tag;
    logic              fill_start = 1'b0;
    logic [AW-1:0]     fill_addr = '0;
    logic              fill_valid = 1'b0;
    logic [DW-1:0]     fill_data = '0;
    logic              fill_done;
    logic              busy;
    logic              flush_all = 1'b0;

    cache_line_store #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LINE_WORDS (LW),
        .NUM_LINES  (NL)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_rdata        (rsp_rdata),
        .rsp_victim_valid (rsp_victim_valid),
        .rsp_victim_dirty (rsp_victim_dirty),
        .rsp_victim_tag   (rsp_victim_tag),
        .fill_start       (fill_start),
        .fill_addr        (fill_addr),
        .fill_valid       (fill_valid),
        .fill_data        (fill_data),
        .fill_done        (fill_done),
        .busy             (busy),
        .flush_all        (flush_all)
    );

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit               hit;
        bit               chk_data;
        logic [DW-1:0]    rdata;
        bit               vvalid;
        bit               vdirty;
        logic [TAG_W-1:0] vtag;
    } rsp_t;

    rsp_t exp_q[$];

    bit               m_valid [NL];
    bit               m_dirty [NL];
    logic [TAG_W-1:0] m_tag   [NL];
    logic [DW-1:0]    m_data  [NL][LW];
    logic [DW-1:0]    m_buf   [LW];
    bit               m_filling;
    int               m_fill_line;
    logic [TAG_W-1:0] m_fill_tag;
    int               m_beats;
    bit               m_accepted;
    bit               exp_fill_done;
    int               exp_done_cnt = 0;
    int               seen_done_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int line_of(logic [AW-1:0] a);
        return int'((a / LW) % NL);
    endfunction

    function automatic int word_of(logic [AW-1:0] a);
        return int'(a % LW);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(logic [AW-1:0] a);
        return TAG_W'(a / (LW * NL));
    endfunction

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_filling     = 1'b0;
        m_beats       = 0;
        m_accepted    = 1'b0;
        exp_fill_done = 1'b0;
        exp_q.delete();
    endfunction

    // Applies the inputs held across this clock edge to the model.
    function automatic void model_step();
        rsp_t e;
        int   ln;
        exp_fill_done = 1'b0;
        m_accepted    = 1'b0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (flush_all) begin
            for (int i = 0; i < NL; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            m_filling = 1'b0;
        end else if (!m_filling) begin
            if (fill_start) begin
                m_fill_line          = line_of(fill_addr);
                m_fill_tag           = tag_of(fill_addr);
                m_valid[m_fill_line] = 1'b0;
                m_filling            = 1'b1;
                m_beats              = 0;
            end else if (req_valid) begin
                ln         = line_of(req_addr);
                e.hit      = m_valid[ln] && (m_tag[ln] == tag_of(req_addr));
                e.chk_data = e.hit && !req_we;
                e.rdata    = m_data[ln][word_of(req_addr)];
                e.vvalid   = m_valid[ln];
                e.vdirty   = m_dirty[ln];
                e.vtag     = m_tag[ln];
                exp_q.push_back(e);
                m_accepted = 1'b1;
                if (req_we && e.hit) begin
                    m_data[ln][word_of(req_addr)] = req_wdata;
                    m_dirty[ln]                   = 1'b1;
                end
            end
        end else if (fill_valid) begin
            m_buf[m_beats] = fill_data;
            m_beats++;
            if (m_beats == LW) begin
                // Line becomes visible only once the whole burst has landed.
                for (int w = 0; w < LW; w++) m_data[m_fill_line][w] = m_buf[w];
                m_valid[m_fill_line] = 1'b1;
                m_dirty[m_fill_line] = 1'b0;
                m_tag[m_fill_line]   = m_fill_tag;
                m_filling            = 1'b0;
                exp_fill_done        = 1'b1;
                exp_done_cnt++;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        rsp_t e;
        check("busy", 64'(busy), 64'(m_filling));
        check("req_ready", 64'(req_ready), 64'(!m_filling && !fill_start && !flush_all));
        check("fill_done", 64'(fill_done), 64'(exp_fill_done));
        if (fill_done === 1'b1) seen_done_cnt++;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
                if (e.chk_data) check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("victim_valid", 64'(rsp_victim_valid), 64'(e.vvalid));
                check("victim_dirty", 64'(rsp_victim_dirty), 64'(e.vdirty));
                check("victim_tag", 64'(rsp_victim_tag), 64'(e.vtag));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_missing", 64'(rsp_valid), 64'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_we     = 1'b0;
        fill_start = 1'b0;
        fill_valid = 1'b0;
        flush_all  = 1'b0;
    endtask

    task automatic lookup(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    // Full burst refill; one idle gap after beat index gap_at (-1 = none).
    task automatic do_fill(input logic [AW-1:0] a, input logic [DW-1:0] base, input int gap_at);
        fill_start = 1'b1;
        fill_addr  = a;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < LW; i++) begin
            fill_valid = 1'b1;
            fill_data  = base + DW'(i);
            tick();
            fill_valid = 1'b0;
            if (i == gap_at) tick();
        end
        fill_valid = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] t, ix, o;
        t  = AW'($urandom_range(0, 3));
        ix = AW'($urandom_range(0, NL - 1));
        o  = AW'($urandom_range(0, LW - 1));
        return (t << (IDX_W + OFF_W)) | (ix << OFF_W) | o;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        model_reset();
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Cold lookup misses with an empty victim.
        lookup(1'b0, 32'h40, 8'h00);
        tick();

        // Refill 0x40 with a gap, then read every word back.
        do_fill(32'h40, 8'hA0, 1);
        tick();
        for (int i = 0; i < LW; i++) lookup(1'b0, 32'h40 + 32'(i), 8'h00);

        // Write hit, readback, conflicting lookup sees a dirty victim.
        lookup(1'b1, 32'h41, 8'h5C);
        lookup(1'b0, 32'h41, 8'h00);
        lookup(1'b0, 32'h60, 8'h00);
        lookup(1'b1, 32'h63, 8'h77);
        tick();

        // Request and fill_start together: fill wins, request waits.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h42;
        fill_start = 1'b1;
        fill_addr  = 32'h60;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < LW; i++) begin
            fill_valid = 1'b1;
            fill_data  = 8'hB0 + DW'(i);
            tick();
        end
        fill_valid = 1'b0;
        for (int k = 0; k < 20 && !m_accepted; k++) tick();
        if (!m_accepted) check("held_req_accept_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
        lookup(1'b0, 32'h61, 8'h00);

        // Flush partway through a fill at 0x80.
        fill_start = 1'b1;
        fill_addr  = 32'h80;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fill_valid = 1'b1;
            fill_data  = 8'hC0 + DW'(i);
            tick();
        end
        fill_valid = 1'b0;
        flush_all  = 1'b1;
        tick();
        flush_all  = 1'b0;
        tick();
        lookup(1'b0, 32'h40, 8'h00);
        lookup(1'b0, 32'h80, 8'h00);

        // Asynchronous reset mid-fill.
        do_fill(32'h44, 8'hD0, -1);
        fill_start = 1'b1;
        fill_addr  = 32'hC0;
        tick();
        fill_start = 1'b0;
        fill_valid = 1'b1;
        fill_data  = 8'hE0;
        tick();
        fill_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("busy_async_reset", 64'(busy), 64'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
        lookup(1'b0, 32'hC0, 8'h00);
        lookup(1'b0, 32'h44, 8'h00);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            req_valid  = ($urandom_range(0, 99) < 60);
            req_we     = 1'($urandom_range(0, 1));
            req_addr   = rand_addr();
            req_wdata  = DW'($urandom);
            fill_start = ($urandom_range(0, 99) < 6);
            fill_addr  = rand_addr();
            fill_valid = ($urandom_range(0, 99) < 70);
            fill_data  = DW'($urandom);
            flush_all  = ($urandom_range(0, 299) == 0);
            tick();
        end

        idle_inputs();
        tick();
        tick();
        tick();
        check("fill_done_count", 64'(seen_done_cnt), 64'(exp_done_cnt));
        check("rsp_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_store.md
Name: cache_line_store

Overview:
Parametrised direct-mapped cache storage: multi-word lines with per-line tag, valid and dirty state, hit detection, and a burst line-refill port. It replaces the flat word-indexed cache array and sits between the cache controller FSM and the main-memory interface. Lookups are registered with 1-cycle latency. Victim information is returned on every lookup so the controller can schedule write-back.

Parameters:
ADDR_WIDTH, 32, byte/word address width
DATA_WIDTH, 8, bits per word
LINE_WORDS, 4, words per line (power of 2, >=2)
NUM_LINES, 8, number of lines (power of 2, >=2)
Derived: OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(NUM_LINES), TAG_W=ADDR_WIDTH-IDX_W-OFF_W; addr = {tag, index, offset}.

Ports:
clk  in  1  clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request
req_ready  out  1  = (state==IDLE) && !fill_start && !flush_all (combinational)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request word address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  1-cycle pulse, cycle after request accepted
rsp_hit  out  1  tag match and line valid
rsp_rdata  out  DATA_WIDTH  read word (meaningful on read hit only)
rsp_victim_valid  out  1  indexed line valid at lookup
rsp_victim_dirty  out  1  indexed line dirty at lookup
rsp_victim_tag  out  TAG_W  indexed line tag at lookup
fill_start  in  1  begin refill of line given by fill_addr
fill_addr  in  ADDR_WIDTH  refill address (offset bits ignored)
fill_valid  in  1  refill data beat valid
fill_data  in  DATA_WIDTH  refill word
fill_done  out  1  1-cycle pulse after last beat written
busy  out  1  high in FILL state
flush_all  in  1  invalidate every line

Behaviour:
- Reset (reset_n=0, async): state=IDLE, beat counter=0, all valid and dirty bits 0, tags 0; all outputs 0 except req_ready (follows its equation). Data array is not reset.
- FSM states: IDLE, FILL.
- IDLE: request accepted when req_valid && req_ready. Next cycle: rsp_valid=1, rsp_hit/victim fields reflect state before the access. Read hit: rsp_rdata=word[index][offset]. Write hit: word written, dirty[index]=1 at the accepting edge. Write miss: no array update (no-allocate); controller refills and retries. Back-to-back requests every cycle are supported.
- Priority in IDLE, same cycle: flush_all > fill_start > request. The loser is not accepted; the requester holds req_valid.
- fill_start in IDLE: latch index and tag, valid[index]=0, counter=0, go to FILL.
- FILL: each fill_valid writes fill_data to word[index][counter], counter+1. Gaps (fill_valid=0) are allowed. On the beat with counter==LINE_WORDS-1: valid=1, tag=latched tag, dirty=0, counter wraps to 0, state=IDLE, fill_done=1 next cycle. fill_start during FILL is ignored. Requests are not accepted in FILL.
- flush_all (any state): all valid and dirty bits cleared at the edge. If in FILL, the fill is aborted: IDLE, counter=0, no fill_done. Remaining beats are the controller's responsibility to drop.
- Reset asserted mid-fill: immediate return to reset state.
- Widths: no arithmetic beyond the OFF_W counter, which wraps modulo LINE_WORDS.

Test Plan (defaults; addr 0x40 -> tag=2, index=0, offset=0):
- Reset, then read 0x40 -> rsp_valid=1 next cycle, rsp_hit=0, victim_valid=0, victim_dirty=0.
- fill_start addr 0x40, beats 0xA0,0xA1,0xA2,0xA3 (with one idle gap) -> busy for fill, fill_done pulse once; reads 0x40..0x43 hit with 0xA0..0xA3, victim_tag=2.
- Write 0x41 data 0x5C, then read 0x41 -> hit, rdata 0x5C; lookup 0x60 (tag 3, index 0) -> hit=0, victim_valid=1, victim_dirty=1, victim_tag=2.
- req_valid and fill_start in the same cycle -> req_ready=0, fill proceeds; request accepted the first IDLE cycle after fill_done.
- flush_all after beat 2 of a fill at 0x80 -> no fill_done, busy=0 next cycle; reads 0x40 and 0x80 miss with victim_valid=0.
- reset_n pulsed low mid-fill, asynchronously between edges -> busy=0 immediately; a subsequent lookup misses.
